// File: rtl/ball_engine.sv
// Pong ball engine: serve sequencing, sub-pixel accumulator motion,
// wall exits/bounces and paddle edge/face collisions with speed-up.
module ball_engine #(
   parameter int unsigned H_VIDEO      = 640,
   parameter int unsigned V_VIDEO      = 480,
   parameter int unsigned BALL_W       = 16,
   parameter int unsigned PDL_W        = 12,
   parameter int unsigned PDL_H        = 96,
   parameter int unsigned TICK_HZ      = 25_175_000,
   parameter int unsigned MIN_VEL      = 400,
   parameter int unsigned MAX_VEL      = 500,
   parameter int unsigned VEL_STEP     = 20,
   parameter int unsigned SPEEDUP_EN   = 1,
   parameter int unsigned VEL_Y_GAIN   = 2,
   parameter int unsigned SERVE_CYCLES = 50_352_112,
   parameter int unsigned AUTO_SERVE   = 1
) (
   input  logic       clk_0,
   input  logic       rst,
   input  logic       start,
   input  logic       halt,
   input  logic [9:0] pdl1_xpos,
   input  logic [9:0] pdl1_ypos,
   input  logic [9:0] pdl2_xpos,
   input  logic [9:0] pdl2_ypos,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       ball_shown,
   output logic       miss_left,
   output logic       miss_right,
   output logic       paddle_hit,
   output logic [6:0] hit_y,
   output logic [1:0] state
);
   localparam int unsigned VW     = $clog2(MAX_VEL + 1);
   localparam int unsigned AW     = 25;
   localparam int unsigned SW     = AW + 1;
   localparam int unsigned PW     = 11;
   localparam int unsigned CW     = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
   localparam int unsigned HALF_H = PDL_H / 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SERVE = 2'd1,
      S_PLAY  = 2'd2,
      S_MISS  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [9:0]    bx_q, bx_d, by_q, by_d;
   logic [AW-1:0] ax_q, ax_d, ay_q, ay_d;
   logic [VW-1:0] vx_q, vx_d, vy_q, vy_d;
   logic          dx_q, dx_d, dy_q, dy_d, sdx_q, sdx_d, sdy_q, sdy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ml_q, ml_d, mr_q, mr_d, hit_q, hit_d, shown_q, shown_d;
   logic [6:0]    hy_q, hy_d;

   // Closed-interval overlap of ball square and paddle rectangle.
   function automatic logic overlap(input logic [PW-1:0] bx, by, px, py);
      return (bx <= px + PW'(PDL_W)) && (px <= bx + PW'(BALL_W)) &&
             (by <= py + PW'(PDL_H)) && (py <= by + PW'(BALL_W));
   endfunction

   logic [PW-1:0] bx_w, by_w, py_sel, ball_c, pdl_c, off;
   logic          wall_r, wall_l, y_bottom, y_top, ovl_r, ovl_l, exit_c;
   logic          edge_top, edge_bot;
   logic [6:0]    hy_face;
   logic [31:0]   vy_sum, vx_sum;
   logic [SW-1:0] sum_x, sum_y;

   assign bx_w     = PW'(bx_q);
   assign by_w     = PW'(by_q);
   assign wall_r   = bx_w >= PW'(H_VIDEO - BALL_W - 1);
   assign wall_l   = bx_w == '0;
   assign y_bottom = by_w >= PW'(V_VIDEO - BALL_W - 1);
   assign y_top    = by_w == '0;
   assign exit_c   = wall_r | wall_l;
   assign ovl_r    = overlap(bx_w, by_w, PW'(pdl2_xpos), PW'(pdl2_ypos));
   assign ovl_l    = overlap(bx_w, by_w, PW'(pdl1_xpos), PW'(pdl1_ypos));
   assign py_sel   = ovl_r ? PW'(pdl2_ypos) : PW'(pdl1_ypos);
   assign edge_top = (by_w + PW'(BALL_W)) <= (py_sel + PW'(1));
   assign edge_bot = by_w >= (py_sel + PW'(PDL_H - 1));
   assign ball_c   = by_w + PW'(BALL_W / 2);
   assign pdl_c    = py_sel + PW'(HALF_H);
   assign off      = (ball_c >= pdl_c) ? (ball_c - pdl_c) : (pdl_c - ball_c);
   assign hy_face  = (off > PW'(HALF_H)) ? 7'(HALF_H) : off[6:0];
   assign vy_sum   = 32'(MIN_VEL) + 32'(hy_face) * 32'(VEL_Y_GAIN);
   assign vx_sum   = 32'(vx_q) + 32'(VEL_STEP);
   assign sum_x    = SW'(ax_q) + SW'(vx_q);
   assign sum_y    = SW'(ay_q) + SW'(vy_q);

   always_ff @(posedge clk_0) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SERVE;
         S_SERVE: if (cnt_q == CW'(SERVE_CYCLES - 1)) state_d = S_PLAY;
         S_PLAY:  if (exit_c) state_d = S_MISS;
         S_MISS:  state_d = (AUTO_SERVE != 0) ? S_SERVE : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (halt) state_d = S_IDLE;
   end

   always_comb begin
      bx_d    = bx_q;
      by_d    = by_q;
      ax_d    = ax_q;
      ay_d    = ay_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      sdx_d   = sdx_q;
      sdy_d   = sdy_q;
      hy_d    = hy_q;
      ml_d    = 1'b0;
      mr_d    = 1'b0;
      hit_d   = 1'b0;
      shown_d = (state_d == S_PLAY);
      cnt_d   = (state_q == S_SERVE && state_d == S_SERVE) ? cnt_q + CW'(1) : '0;

      // Next serve heads toward whichever side just conceded.
      if (state_q == S_PLAY && !halt) begin
         if (wall_r) begin
            mr_d  = 1'b1;
            sdx_d = 1'b1;
         end else if (wall_l) begin
            ml_d  = 1'b1;
            sdx_d = 1'b0;
         end
      end

      if (state_d != S_PLAY) begin
         bx_d = 10'((H_VIDEO - BALL_W) / 2);
         by_d = 10'((V_VIDEO - BALL_W) / 2);
         ax_d = '0;
         ay_d = '0;
         vx_d = VW'(MIN_VEL);
         vy_d = VW'(MIN_VEL);
      end else if (state_q != S_PLAY) begin
         dx_d  = sdx_q;
         dy_d  = sdy_q;
         sdy_d = ~sdy_q;
      end else if (y_bottom) begin
         dy_d = 1'b0;
         by_d = by_q - 10'd1;
      end else if (y_top) begin
         dy_d = 1'b1;
         by_d = by_q + 10'd1;
      end else if (ovl_r || ovl_l) begin
         hit_d = 1'b1;
         if (edge_top || edge_bot) begin
            dy_d = ~dy_q;
            by_d = edge_top ? by_q - 10'd1 : by_q + 10'd1;
            hy_d = 7'(HALF_H);
         end else begin
            dx_d = ~ovl_r;
            bx_d = ovl_r ? bx_q - 10'd1 : bx_q + 10'd1;
            hy_d = hy_face;
            dy_d = (ball_c >= pdl_c);
            vy_d = (vy_sum > 32'(MAX_VEL)) ? VW'(MAX_VEL) : VW'(vy_sum);
            if (SPEEDUP_EN != 0)
               vx_d = (vx_sum > 32'(MAX_VEL)) ? VW'(MAX_VEL) : VW'(vx_sum);
         end
      end else begin
         if (sum_x >= SW'(TICK_HZ)) begin
            ax_d = AW'(sum_x - SW'(TICK_HZ));
            bx_d = dx_q ? bx_q + 10'd1 : bx_q - 10'd1;
         end else begin
            ax_d = AW'(sum_x);
         end
         if (sum_y >= SW'(TICK_HZ)) begin
            ay_d = AW'(sum_y - SW'(TICK_HZ));
            by_d = dy_q ? by_q + 10'd1 : by_q - 10'd1;
         end else begin
            ay_d = AW'(sum_y);
         end
      end
   end

   always_ff @(posedge clk_0) begin
      if (rst) begin
         bx_q    <= 10'((H_VIDEO - BALL_W) / 2);
         by_q    <= 10'((V_VIDEO - BALL_W) / 2);
         ax_q    <= '0;
         ay_q    <= '0;
         vx_q    <= VW'(MIN_VEL);
         vy_q    <= VW'(MIN_VEL);
         dx_q    <= 1'b0;
         dy_q    <= 1'b0;
         sdx_q   <= 1'b0;
         sdy_q   <= 1'b0;
         cnt_q   <= '0;
         ml_q    <= 1'b0;
         mr_q    <= 1'b0;
         hit_q   <= 1'b0;
         shown_q <= 1'b0;
         hy_q    <= '0;
      end else begin
         bx_q    <= bx_d;
         by_q    <= by_d;
         ax_q    <= ax_d;
         ay_q    <= ay_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         sdx_q   <= sdx_d;
         sdy_q   <= sdy_d;
         cnt_q   <= cnt_d;
         ml_q    <= ml_d;
         mr_q    <= mr_d;
         hit_q   <= hit_d;
         shown_q <= shown_d;
         hy_q    <= hy_d;
      end
   end

   assign ball_x     = bx_q;
   assign ball_y     = by_q;
   assign ball_shown = shown_q;
   assign miss_left  = ml_q;
   assign miss_right = mr_q;
   assign paddle_hit = hit_q;
   assign hit_y      = hy_q;
   assign state      = state_q;
endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: directed scenarios plus randomized play,
// every cycle compared against an integer reference model of the game rules.
module tb_ball_engine;
   localparam int H = 640, V = 480, BW = 16, PDW = 12, PH = 96;
   localparam int TICK = 1000, VMIN = 400, VMAX = 500, STEP = 20, GAIN = 2, SC = 4;
   localparam int XC = (H - BW) / 2, YC = (V - BW) / 2;

   logic       clk_0, rst, start, halt;
   logic [9:0] pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos;
   logic [9:0] ball_x, ball_y;
   logic       ball_shown, miss_left, miss_right, paddle_hit;
   logic [6:0] hit_y;
   logic [1:0] state;

   ball_engine #(.SERVE_CYCLES(SC), .TICK_HZ(TICK)) dut (
      .clk_0(clk_0), .rst(rst), .start(start), .halt(halt),
      .pdl1_xpos(pdl1_xpos), .pdl1_ypos(pdl1_ypos),
      .pdl2_xpos(pdl2_xpos), .pdl2_ypos(pdl2_ypos),
      .ball_x(ball_x), .ball_y(ball_y), .ball_shown(ball_shown),
      .miss_left(miss_left), .miss_right(miss_right), .paddle_hit(paddle_hit),
      .hit_y(hit_y), .state(state)
   );

   initial clk_0 = 1'b0;
   always #5 clk_0 = ~clk_0;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
         if (n_err >= 40) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
         end
      end
   endtask

   // Reference model: game state as plain integers, directions as +1/-1.
   int m_state, m_bx, m_by, m_ax, m_ay, m_vx, m_vy, m_dx, m_dy, m_sdx, m_sdy;
   int m_cnt, m_hy;
   bit m_ml, m_mr, m_hit, m_shown;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction
   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
   function automatic bit touches(input int px, input int py);
      return imax(m_bx, px) <= imin(m_bx + BW, px + PDW) &&
             imax(m_by, py) <= imin(m_by + BW, py + PH);
   endfunction

   task automatic model_reset();
      m_state = 0; m_bx = XC; m_by = YC; m_ax = 0; m_ay = 0;
      m_vx = VMIN; m_vy = VMIN; m_dx = -1; m_dy = -1; m_sdx = -1; m_sdy = -1;
      m_cnt = 0; m_hy = 0; m_ml = 0; m_mr = 0; m_hit = 0; m_shown = 0;
   endtask

   task automatic contact(input int py, input bit right_side);
      int ofs;
      m_hit = 1;
      if (m_by + BW <= py + 1) begin
         m_dy = -m_dy; m_by = m_by - 1; m_hy = PH / 2;
      end else if (m_by >= py + PH - 1) begin
         m_dy = -m_dy; m_by = m_by + 1; m_hy = PH / 2;
      end else begin
         m_dx = right_side ? -1 : 1;
         m_bx = m_bx + m_dx;
         ofs  = (m_by + BW / 2) - (py + PH / 2);
         m_dy = (ofs >= 0) ? 1 : -1;
         m_hy = imin((ofs < 0) ? -ofs : ofs, PH / 2);
         m_vy = imin(VMIN + m_hy * GAIN, VMAX);
         m_vx = imin(m_vx + STEP, VMAX);
      end
   endtask

   task automatic advance(inout int acc, inout int pos, input int vel, input int dir);
      acc = acc + vel;
      if (acc >= TICK) begin
         acc = acc - TICK;
         pos = pos + dir;
      end
   endtask

   task automatic model_step();
      int ns;
      m_ml = 0; m_mr = 0; m_hit = 0;
      if (rst) begin
         model_reset();
         return;
      end
      case (m_state)
         0:       ns = start ? 1 : 0;
         1:       ns = (m_cnt == SC - 1) ? 2 : 1;
         2:       ns = (m_bx >= H - BW - 1 || m_bx == 0) ? 3 : 2;
         default: ns = 1;
      endcase
      if (halt) ns = 0;
      m_cnt = (m_state == 1 && ns == 1) ? m_cnt + 1 : 0;
      if (m_state == 2 && !halt) begin
         if (m_bx >= H - BW - 1) begin m_mr = 1; m_sdx = 1;  end
         else if (m_bx == 0)     begin m_ml = 1; m_sdx = -1; end
      end
      if (ns != 2) begin
         m_bx = XC; m_by = YC; m_ax = 0; m_ay = 0; m_vx = VMIN; m_vy = VMIN;
      end else if (m_state != 2) begin
         m_dx = m_sdx; m_dy = m_sdy; m_sdy = -m_sdy;
      end else if (m_by >= V - BW - 1) begin
         m_dy = -1; m_by = m_by - 1;
      end else if (m_by == 0) begin
         m_dy = 1; m_by = 1;
      end else if (touches(int'(pdl2_xpos), int'(pdl2_ypos))) begin
         contact(int'(pdl2_ypos), 1'b1);
      end else if (touches(int'(pdl1_xpos), int'(pdl1_ypos))) begin
         contact(int'(pdl1_ypos), 1'b0);
      end else begin
         advance(m_ax, m_bx, m_vx, m_dx);
         advance(m_ay, m_by, m_vy, m_dy);
      end
      m_state = ns;
      m_shown = (ns == 2);
   endtask

   task automatic compare_all();
      check("state",  int'(state),      m_state);
      check("ball_x", int'(ball_x),     m_bx);
      check("ball_y", int'(ball_y),     m_by);
      check("shown",  int'(ball_shown), int'(m_shown));
      check("miss_l", int'(miss_left),  int'(m_ml));
      check("miss_r", int'(miss_right), int'(m_mr));
      check("hit",    int'(paddle_hit), int'(m_hit));
      check("hit_y",  int'(hit_y),      m_hy);
   endtask

   task automatic cyc();
      @(posedge clk_0);
      #1;
      model_step();
      compare_all();
   endtask

   initial begin
      int k, hits;
      int seq[5] = '{1, 1, 1, 1, 2};
      rst = 1'b1; start = 1'b0; halt = 1'b0;
      pdl1_xpos = 10'd1000; pdl1_ypos = 10'd0;
      pdl2_xpos = 10'd1000; pdl2_ypos = 10'd0;
      model_reset();
      cyc();
      check("rst_state", int'(state), 0);
      check("rst_x", int'(ball_x), 312);
      check("rst_y", int'(ball_y), 232);

      // First serve: four SERVE cycles, then PLAY with the ball shown.
      rst = 1'b0; start = 1'b1;
      foreach (seq[i]) begin
         cyc();
         start = 1'b0;
         check("serve_seq", int'(state), seq[i]);
      end
      check("shown_play", int'(ball_shown), 1);
      check("play_x0", int'(ball_x), 312);

      // 500 free cycles at 400 px/s: 200 px on both axes, up-left.
      repeat (500) cyc();
      check("drift_x", int'(ball_x), 112);
      check("drift_y", int'(ball_y), 32);

      k = 0;
      while (!miss_left && k < 1500) begin cyc(); k++; end
      check("miss_left_seen", int'(miss_left), 1);
      check("miss_right_quiet", int'(miss_right), 0);
      check("miss_state", int'(state), 3);
      cyc();
      check("reserve_state", int'(state), 1);

      // Second serve heads left and down into a face hit on the left paddle.
      pdl1_xpos = 10'd288; pdl1_ypos = 10'd200;
      k = 0;
      while (state != 2'd2 && k < 20) begin cyc(); k++; end
      check("serve2_play", int'(state), 2);
      repeat (5) cyc();
      check("serve2_x", int'(ball_x), 310);
      check("serve2_y", int'(ball_y), 234);
      k = 0;
      while (!paddle_hit && k < 200) begin cyc(); k++; end
      check("face_hit", int'(paddle_hit), 1);
      check("face_hit_y", int'(hit_y), 4);
      check("face_bx", int'(ball_x), 301);
      check("face_by", int'(ball_y), 244);

      // Paddle pushed into the ball: seven more face hits, speed caps at 500.
      pdl1_xpos = 10'd295;
      hits = 0;
      repeat (10) begin cyc(); hits += int'(paddle_hit); end
      check("push_hits", hits, 7);
      check("push_x", int'(ball_x), 309);
      repeat (200) cyc();
      check("vmax_x", int'(ball_x), 409);

      halt = 1'b1;
      cyc();
      halt = 1'b0;
      check("halt_state", int'(state), 0);
      check("halt_x", int'(ball_x), 312);
      check("halt_y", int'(ball_y), 232);
      check("halt_no_miss", int'(miss_left) + int'(miss_right), 0);

      // Reset during SERVE clears the serve counter.
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rst_serve_state", int'(state), 0);
      start = 1'b1;
      foreach (seq[i]) begin
         cyc();
         start = 1'b0;
         check("rst_serve_seq", int'(state), seq[i]);
      end

      // Randomized play against the model.
      for (int i = 0; i < 8000; i++) begin
         rst   = ($urandom_range(0, 2999) == 0);
         halt  = ($urandom_range(0, 599) == 0);
         start = ($urandom_range(0, 7) == 0);
         if (i % 64 == 0) begin
            pdl1_xpos = 10'($urandom_range(20, 60));
            pdl1_ypos = 10'($urandom_range(0, 383));
            pdl2_xpos = 10'($urandom_range(560, 600));
            pdl2_ypos = 10'($urandom_range(0, 383));
         end
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- H_VIDEO, 640, field width (px)
- V_VIDEO, 480, field height (lines)
- BALL_W, 16, ball side length (px)
- PDL_W, 12, paddle thickness (px)
- PDL_H, 96, paddle height (px); even
- TICK_HZ, 25_175_000, accumulator threshold (clk_0 cycles per second)
- MIN_VEL, 400, base speed (px/s), both axes
- MAX_VEL, 500, speed ceiling (px/s), both axes
- VEL_STEP, 20, x-speed increment per paddle face hit
- SPEEDUP_EN, 1, 1 = x-speed ramps on face hits; 0 = x-speed fixed at MIN_VEL
- VEL_Y_GAIN, 2, y-speed px/s added per pixel of hit offset
- SERVE_CYCLES, 50_352_112, hidden delay before each serve
- AUTO_SERVE, 1, 1 = re-serve after a miss; 0 = return to IDLE after a miss
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk_0, in, 1, single clock; all logic on its rising edge
- rst, in, 1, synchronous, active-high reset
- start, in, 1, level; serve request from IDLE
- halt, in, 1, level; forces IDLE from any state on the next edge
- pdl1_xpos / pdl1_ypos, in, 10 each, left paddle top-left corner
- pdl2_xpos / pdl2_ypos, in, 10 each, right paddle top-left corner
- ball_x / ball_y, out, 10 each, ball top-left corner
- ball_shown, out, 1, high only in PLAY
- miss_left / miss_right, out, 1 each, one-cycle pulse when the ball exits left (p2 point) or right (p1 point)
- paddle_hit, out, 1, one-cycle pulse on any paddle contact
- hit_y, out, 7, last face-hit offset from paddle centre
- state, out, 2, IDLE=0, SERVE=1, PLAY=2, MISS=3

Function
REQ-003 The FSM SHALL follow these transitions:
- IDLE -> SERVE when start=1.
- SERVE -> PLAY after SERVE_CYCLES cycles.
- PLAY -> MISS on a wall exit.
- MISS -> SERVE after 1 cycle if AUTO_SERVE=1, else MISS -> IDLE.
- halt=1 overrides all of the above: IDLE next cycle.
REQ-004 In IDLE, SERVE and MISS: ball_x=(H_VIDEO-BALL_W)/2, ball_y=(V_VIDEO-BALL_W)/2, both accumulators 0, vel_x=MIN_VEL, vel_y=MIN_VEL.
REQ-005 The serve counter SHALL clear on SERVE entry; PLAY is entered on the edge where count==SERVE_CYCLES-1.
REQ-006 Serve x-direction SHALL be toward the side that conceded the last point; after reset, toward the left. Serve y-direction SHALL alternate on every serve, starting upward.
REQ-007 Motion, each PLAY cycle, per axis:
- If acc+vel >= TICK_HZ: acc <= acc+vel-TICK_HZ and the position steps 1 px in the current direction.
- Else acc <= acc+vel.
- Accumulators are 25 bits; vel is $clog2(MAX_VEL+1) bits.
REQ-008 Collision checks SHALL be evaluated on the current registered position. Only the first matching case acts per cycle, in this priority:
- (a) ball_x >= H_VIDEO-BALL_W-1: miss_right pulse, MISS.
- (b) ball_x == 0: miss_left pulse, MISS.
- (c) ball_y >= V_VIDEO-BALL_W-1: y-direction set up, ball_y -1.
- (d) ball_y == 0: y-direction set down, ball_y +1.
- (e) right paddle overlap.
- (f) left paddle overlap.
- Stepping (REQ-007) is suppressed on cycles where any case acts.
REQ-009 Paddle overlap SHALL mean x-ranges [ball_x, ball_x+BALL_W] and [pdl_x, pdl_x+PDL_W] intersect AND y-ranges [ball_y, ball_y+BALL_W] and [pdl_y, pdl_y+PDL_H] intersect. All comparisons are 11-bit unsigned.
REQ-010 Edge hit (ball_y+BALL_W <= pdl_y+1 or ball_y >= pdl_y+PDL_H-1):
- y-direction inverts; ball moves 1 px away vertically.
- hit_y=PDL_H/2; vel_x unchanged.
REQ-011 Face hit (any other overlap):
- x-direction set away from the paddle; ball moves 1 px away horizontally.
- hit_y = |ball centre - paddle centre|, saturated at PDL_H/2.
- y-direction set toward the side of the offset; down when ball centre == paddle centre.
- vel_y = min(MIN_VEL + hit_y*VEL_Y_GAIN, MAX_VEL).
- If SPEEDUP_EN=1: vel_x = min(vel_x+VEL_STEP, MAX_VEL).
REQ-012 paddle_hit SHALL pulse for exactly one cycle per contact cycle. miss_left and miss_right are never asserted together.

Reset
REQ-013 rst=1 at a clock edge SHALL force, on that edge:
- state=IDLE, ball centred, ball_shown=0, all pulses 0, hit_y=0
- accumulators 0, serve counter 0, vel_x=vel_y=MIN_VEL
- serve x-direction left, serve y-direction up
REQ-014 Reset SHALL take priority over halt and start. Reset mid-PLAY leaves no miss or hit pulse.

Verification
REQ-015 The bench SHALL use SERVE_CYCLES=4 and TICK_HZ=1000, and SHALL cover:
- Reset, then start=1 -> state 0,1,1,1,1,2; ball_shown rises with state=2; ball at (312,232).
- PLAY, vel 400, no paddles in path -> ball_x decrements by 1 every 2.5 cycles on average; after 1000 cycles it has moved 400 px.
- Ball drifts to ball_x=0 -> one miss_left pulse, state=3 then 1; next serve heads left with y-direction down.
- Face hit on pdl1 (pdl1_ypos=200) with ball_y=244 (offset 4) -> paddle_hit pulse; hit_y=4; vel_y=408; vel_x=420; x-direction right.
- Repeated face hits with SPEEDUP_EN=1 -> vel_x saturates at 500.
- halt=1 mid-PLAY -> IDLE next cycle, ball centred, no miss pulse; rst=1 during SERVE -> counter cleared, state=0.
